// File: rtl/if_id_stage_if.sv
// Bundle of control, fetch and IF/ID signals between the hazard/branch logic,
// instruction memory and the fetch stage. The master drives the stall and
// redirect controls plus the memory read data. The slave is the fetch stage.
interface if_id_stage_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 pc_write;
  logic                 if_id_write;
  logic                 branch_taken;
  logic [31:0]          branch_target;
  logic [31:0]          imem_instruction;
  logic [31:0]          pc;
  logic [31:0]          if_id_instruction;
  logic [31:0]          if_id_pc_plus4;
  logic                 if_id_valid;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output pc_write, if_id_write, branch_taken, branch_target, imem_instruction,
    input  pc, if_id_instruction, if_id_pc_plus4, if_id_valid,
           stall_count, flush_count
  );

  modport slave (
    input  pc_write, if_id_write, branch_taken, branch_target, imem_instruction,
    output pc, if_id_instruction, if_id_pc_plus4, if_id_valid,
           stall_count, flush_count
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage: owns the program counter and the IF/ID pipeline register,
// obeys hold requests from hazard detection and redirect/flush from branch
// resolution, and keeps saturating stall/flush event counters.
// Every output comes straight from a register.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter int          CNT_WIDTH = 16
) (
  input  logic          i_clock,
  input  logic          i_reset,
  if_id_stage_if.slave  bus
);

  logic [31:0]          r_pc;
  logic [31:0]          r_if_id_instruction;
  logic [31:0]          r_if_id_pc_plus4;
  logic                 r_if_id_valid;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  logic [31:0]          w_pc_seq;
  logic [31:0]          w_pc_next;
  logic                 w_flush;
  logic                 w_stall_event;
  logic [CNT_WIDTH-1:0] w_stall_next;
  logic [CNT_WIDTH-1:0] w_flush_next;

  // Sequential address wraps modulo 2^32 by simply dropping the carry.
  assign w_pc_seq = r_pc + PC_STEP;

  // A flush only takes effect when IF/ID is allowed to load; a held IF/ID
  // keeps its instruction so the branch can re-resolve later.
  assign w_flush       = bus.branch_taken & bus.if_id_write;
  assign w_stall_event = ~bus.pc_write;

  // Next PC: hold beats redirect, redirect beats sequential fetch.
  always_comb begin
    w_pc_next = r_pc;
    if (bus.pc_write) begin
      if (bus.branch_taken) w_pc_next = bus.branch_target;
      else                  w_pc_next = w_pc_seq;
    end
  end

  // Saturating increments; an all-ones counter stays put.
  always_comb begin
    w_stall_next = r_stall_count;
    w_flush_next = r_flush_count;
    if (w_stall_event && !(&r_stall_count)) w_stall_next = r_stall_count + CNT_WIDTH'(1);
    if (w_flush && !(&r_flush_count))       w_flush_next = r_flush_count + CNT_WIDTH'(1);
  end

  // Program counter register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_pc <= RESET_PC;
    else         r_pc <= w_pc_next;
  end

  // IF/ID register: hold, bubble on flush, or capture the current fetch.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_if_id_instruction <= 32'h0000_0000;
      r_if_id_pc_plus4    <= 32'h0000_0000;
      r_if_id_valid       <= 1'b0;
    end else if (!bus.if_id_write) begin
      r_if_id_instruction <= r_if_id_instruction;
      r_if_id_pc_plus4    <= r_if_id_pc_plus4;
      r_if_id_valid       <= r_if_id_valid;
    end else if (w_flush) begin
      r_if_id_instruction <= 32'h0000_0000;
      r_if_id_pc_plus4    <= 32'h0000_0000;
      r_if_id_valid       <= 1'b0;
    end else begin
      r_if_id_instruction <= bus.imem_instruction;
      r_if_id_pc_plus4    <= w_pc_seq;
      r_if_id_valid       <= 1'b1;
    end
  end

  // Performance counters.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_stall_count <= w_stall_next;
      r_flush_count <= w_flush_next;
    end
  end

  assign bus.pc                = r_pc;
  assign bus.if_id_instruction = r_if_id_instruction;
  assign bus.if_id_pc_plus4    = r_if_id_pc_plus4;
  assign bus.if_id_valid       = r_if_id_valid;
  assign bus.stall_count       = r_stall_count;
  assign bus.flush_count       = r_flush_count;

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch-side responder to the pipeline's stall controls.
- Owns the program counter and the IF/ID pipeline register.
- Honours the hold requests (pc_write, if_id_write) raised by hazard detection, and the redirect/flush raised by branch resolution in ID.
- Keeps saturating stall and flush event counters for performance debug.
- Sits between instruction memory (combinational read) and the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- CNT_WIDTH, 16, width of stall_count and flush_count.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_write  input  1  1 = PC may update; 0 = hold PC (stall).
- if_id_write  input  1  1 = IF/ID may update; 0 = hold IF/ID (stall).
- branch_taken  input  1  branch/jump resolved taken in ID this cycle.
- branch_target  input  32  redirect address, valid when branch_taken=1.
- imem_instruction  input  32  instruction word read combinationally at address pc.
- pc  output  32  current fetch address; drives the instruction memory address.
- if_id_instruction  output  32  registered instruction presented to ID.
- if_id_pc_plus4  output  32  registered pc+PC_STEP of that instruction.
- if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- stall_count  output  CNT_WIDTH  number of cycles with pc_write=0, saturating.
- flush_count  output  CNT_WIDTH  number of flushes applied, saturating.

Behaviour:
- Reset (reset=1 at a rising edge) dominates every other input. It sets:
  - pc=RESET_PC
  - if_id_instruction=32'h0000_0000 (nop)
  - if_id_pc_plus4=0
  - if_id_valid=0
  - stall_count=0, flush_count=0
- Reset mid-stall or mid-flush discards all pending state. The first fetch after reset deasserts is at RESET_PC.
- All outputs are registered; no combinational path runs from the inputs to the outputs.
- Define "adv" as pc_write=1. Define "flush" as branch_taken=1 AND if_id_write=1.
- PC register, evaluated in priority order:
  1. reset
  2. pc_write=0 → hold (branch_taken is ignored; the held branch in ID re-resolves on a later cycle)
  3. branch_taken=1 → pc=branch_target
  4. otherwise → pc=pc+PC_STEP
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. No alignment check is made; branch_target is loaded verbatim.
- IF/ID register, evaluated in priority order:
  1. reset
  2. if_id_write=0 → hold all three fields
  3. flush → instruction=0, pc_plus4=0, valid=0
  4. otherwise → instruction=imem_instruction, pc_plus4=pc+PC_STEP (the pre-update pc), valid=1
- pc_write and if_id_write are independent. Every combination is legal:
  - 0/0: full stall.
  - 1/0: PC advances while IF/ID holds. The skipped fetch is lost; upstream is responsible for never requesting this.
  - 0/1: IF/ID reloads from the held pc, so the same instruction is captured again.
- Latency:
  - An instruction fetched at pc in cycle N appears on if_id_instruction in cycle N+1.
  - A taken branch asserted in cycle N makes pc=branch_target in N+1.
  - The wrong-path instruction captured in N is replaced by a bubble in N+1, so there is exactly one bubble.
- Counters:
  - stall_count increments each non-reset cycle with pc_write=0.
  - flush_count increments each cycle a flush is applied.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.
  - A cycle can increment both counters only when pc_write=0, branch_taken=1 and if_id_write=1.

Test Plan:
- Reset, then release with imem returning 32'h2008_0005 at pc=0 → cycle 1: pc=4, if_id_instruction=32'h2008_0005, if_id_pc_plus4=4, if_id_valid=1.
- Run to pc=8, then hold pc_write=0 and if_id_write=0 for 2 cycles → pc stays 8, IF/ID unchanged, stall_count=2. After release, pc=12.
- At pc=16, assert branch_taken with branch_target=32'h0000_0040 → next cycle: pc=0x40, if_id_valid=0, if_id_instruction=0, flush_count=1. The following cycle holds the instruction from 0x40 with valid=1.
- Assert branch_taken together with pc_write=0 and if_id_write=0 → pc, IF/ID and flush_count are unchanged, and stall_count increments.
- Load pc=32'hFFFF_FFFC via branch, then advance → pc=0, and if_id_pc_plus4=0 for the instruction fetched at 0xFFFF_FFFC.
- Use CNT_WIDTH=3 and stall for 10 cycles → stall_count saturates at 7. Assert reset mid-stall → all outputs return to their reset values in the next cycle.
